// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types and decode helpers for the multi-cycle
// phase sequencer and future pipelined control.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERR
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_HOLD
`endif
  } state_t;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_OFS = 2'd1;
  localparam logic [1:0] PC_ALU = 2'd2;

  localparam logic [4:0] JMP_LINK = 5'b11001;
  localparam logic [4:0] JMP_REG  = 5'b11010;
  localparam logic [2:0] LS_PFX   = 3'b011;

  localparam logic [3:0] CC_AL = 4'h0;
  localparam logic [3:0] CC_Z  = 4'h1;
  localparam logic [3:0] CC_NZ = 4'h2;
  localparam logic [3:0] CC_C  = 4'h3;
  localparam logic [3:0] CC_NC = 4'h4;
  localparam logic [3:0] CC_V  = 4'h5;
  localparam logic [3:0] CC_NV = 4'h6;
  localparam logic [3:0] CC_S  = 4'h7;
  localparam logic [3:0] CC_NS = 4'h8;

  function automatic logic is_alu_op(input logic [4:0] op);
    return !op[4] && (op[3:2] != 2'b11);
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op[4:2] == LS_PFX) && op[1];
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return (op[4:2] == LS_PFX) && (op[1:0] == 2'b11);
  endfunction

  // Stores and non-link jumps produce no register result.
  function automatic logic wb_allowed(input logic [4:0] op);
    return !is_store(op) && !(op[4] && (op != JMP_LINK));
  endfunction

endpackage

// File: rtl/cpu_branch_cond.sv
// cpu_branch_cond: evaluates a jump condition code against
// the {C,V,S,Z} flag register.
module cpu_branch_cond
  import cpu_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic c, v, s, z;

  assign {c, v, s, z} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL:   taken = 1'b1;
      CC_Z:    taken = z;
      CC_NZ:   taken = !z;
      CC_C:    taken = c;
      CC_NC:   taken = !c;
      CC_V:    taken = v;
      CC_NV:   taken = !v;
      CC_S:    taken = s;
      CC_NS:   taken = !s;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: FETCH/DECODE/EXEC/MEM/WB multi-cycle control,
// flag register and memory timeout trap. Option: SEQ_SINGLE_STEP_EN.
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int MEM_TMO = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           alu_c,
  input  logic           alu_v,
  input  logic           alu_s,
  input  logic           alu_z,
  input  logic           imem_ack,
  input  logic           dmem_ack,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic           step_mode,
  input  logic           step_go,
`endif
  output logic           imem_req,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic           ir_ld,
  output logic           rf_rd_en,
  output logic           alu_en,
  output logic           wb_en,
  output logic           pc_ld,
  output logic [1:0]     pc_sel,
  output logic [3:0]     flags,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(MEM_TMO + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TMO);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    flags_q;
  logic [4:0]    op;
  logic          tmo;
  logic          taken;
  logic          flag_ld;

  assign op    = opcode[4:0];
  assign tmo   = (cnt_q == TMO);
  assign flags = flags_q;

  cpu_branch_cond u_cond (
    .cond  (op[3:0]),
    .flags (flags_q),
    .taken (taken)
  );

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_ld    = 1'b0;
    rf_rd_en = 1'b0;
    alu_en   = 1'b0;
    wb_en    = 1'b0;
    pc_ld    = 1'b0;
    pc_sel   = PC_INC;
    busy     = 1'b1;
    err      = 1'b0;
    flag_ld  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_ld   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        rf_rd_en = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        flag_ld = is_alu_op(op);
        state_d = is_mem_op(op) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = op[0];
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        wb_en = wb_allowed(op);
        pc_ld = 1'b1;
        unique case (1'b1)
          op == JMP_REG:              pc_sel = PC_ALU;
          op == JMP_LINK:             pc_sel = PC_OFS;
          op[4] && (op[3:0] <= CC_NS): pc_sel = taken ? PC_OFS : PC_INC;
          default:                    pc_sel = PC_INC;
        endcase
        state_d = S_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
        if (step_mode) state_d = S_HOLD;
`endif
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_HOLD: begin
        busy = 1'b0;
        if (step_go || !step_mode) state_d = S_FETCH;
      end
`endif
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter runs only while waiting; FETCH/MEM are always entered
  // from another state, so it starts each access at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (flag_ld) flags_q <= {alu_c, alu_v, alu_s, alu_z};
      if ((state_q == S_FETCH) || (state_q == S_MEM))
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: scoreboard bench for the phase sequencer,
// built with MEM_TMO=4 so the timeout trap is reachable quickly.
module tb_cpu_phase_sequencer;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic       alu_c, alu_v, alu_s, alu_z;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_ld;
  logic       rf_rd_en, alu_en, wb_en, pc_ld;
  logic [1:0] pc_sel;
  logic [3:0] flags;
  logic       busy, err;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step_mode, step_go;
`endif

  typedef struct {
    logic [4:0] op;
    logic       wb;
    logic [1:0] ps;
    logic [3:0] fl;
    int         cyc;
    int         dreq;
    logic       we;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] mflags = 4'h0;
  logic       hold_exp = 1'b0;

  cpu_phase_sequencer #(.OPW(5), .MEM_TMO(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .alu_c    (alu_c),
    .alu_v    (alu_v),
    .alu_s    (alu_s),
    .alu_z    (alu_z),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode),
    .step_go  (step_go),
`endif
    .imem_req (imem_req),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .ir_ld    (ir_ld),
    .rf_rd_en (rf_rd_en),
    .alu_en   (alu_en),
    .wb_en    (wb_en),
    .pc_ld    (pc_ld),
    .pc_sel   (pc_sel),
    .flags    (flags),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_psel(input logic [4:0] op,
                                          input logic [3:0] f);
    logic t;
    if (op == 5'b11010) return 2'd2;
    if (op == 5'b11001) return 2'd1;
    if (!op[4]) return 2'd0;
    case (op[3:0])
      4'd0:    t = 1'b1;
      4'd1:    t = f[0];
      4'd2:    t = !f[0];
      4'd3:    t = f[3];
      4'd4:    t = !f[3];
      4'd5:    t = f[2];
      4'd6:    t = !f[2];
      4'd7:    t = f[1];
      4'd8:    t = !f[1];
      default: t = 1'b0;
    endcase
    return {1'b0, t};
  endfunction

  // Runs one instruction starting on the first cycle of FETCH.
  task automatic exec_instr(input logic [4:0] op, input int idly,
                            input int ddly, input logic [3:0] af);
    exp_t e, g;
    logic st, mem;
    int   fw, dw, cyc, wbn;
    bit   dwe_bad, done;
    st  = (op[4:2] == 3'b011) && (op[1:0] == 2'b11);
    mem = (op[4:2] == 3'b011) && op[1];
    if (!op[4] && (op[3:2] != 2'b11)) mflags = af;
    e.op   = op;
    e.fl   = mflags;
    e.ps   = exp_psel(op, mflags);
    e.wb   = !st && !(op[4] && (op != 5'b11001));
    e.cyc  = idly + 4 + (mem ? ddly + 1 : 0);
    e.dreq = mem ? ddly + 1 : 0;
    e.we   = op[0];
    sb.push_back(e);
    opcode = op;
    {alu_c, alu_v, alu_s, alu_z} = af;
    fw = 0; dw = 0; cyc = 0; wbn = 0;
    dwe_bad = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      imem_ack = imem_req && (fw == idly);
      dmem_ack = dmem_req && (dw == ddly);
      #1;
      cyc++;
      if (imem_req) fw++;
      if (dmem_req) begin
        dw++;
        if (dmem_we !== e.we) dwe_bad = 1;
      end
      if (wb_en) wbn++;
      if (pc_ld === 1'b1) begin
        done = 1;
        g = sb.pop_front();
        total++;
        if (wb_en !== g.wb) begin
          bad++;
          $display("FAIL wb_en op=%b: got %b want %b", g.op, wb_en, g.wb);
        end
        total++;
        if (pc_sel !== g.ps) begin
          bad++;
          $display("FAIL pc_sel op=%b: got %0d want %0d", g.op, pc_sel, g.ps);
        end
        total++;
        if (flags !== g.fl) begin
          bad++;
          $display("FAIL flags op=%b: got %b want %b", g.op, flags, g.fl);
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL pc_ld op=%b: no writeback within cycle budget", op);
      g = sb.pop_front();
    end else begin
      total++;
      if (cyc != g.cyc) begin
        bad++;
        $display("FAIL latency op=%b: got %0d want %0d", g.op, cyc, g.cyc);
      end
      total++;
      if (dw != g.dreq || dwe_bad) begin
        bad++;
        $display("FAIL dmem op=%b: req cycles %0d want %0d, we_err=%0d",
                 g.op, dw, g.dreq, dwe_bad);
      end
      total++;
      if (wbn != (g.wb ? 1 : 0)) begin
        bad++;
        $display("FAIL wb_count op=%b: got %0d want %0d", g.op, wbn, g.wb);
      end
    end
    tick();
    total++;
    if (imem_req !== !hold_exp) begin
      bad++;
      $display("FAIL next_fetch op=%b: imem_req %b want %b",
               op, imem_req, !hold_exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({imem_req, dmem_req, dmem_we, ir_ld, rf_rd_en, alu_en,
         wb_en, pc_ld, pc_sel, busy, err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0",
               {imem_req, dmem_req, dmem_we, ir_ld, rf_rd_en, alu_en,
                wb_en, pc_ld, pc_sel, busy, err});
    end
    total++;
    if (flags !== 4'h0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", flags);
    end
    rst = 1'b0;
    mflags = 4'h0;
    tick();
    total++;
    if (imem_req !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: imem_req %b busy %b want 1 1",
               imem_req, busy);
    end
  endtask

  task automatic test_alu;
    exec_instr(5'b00011, 3, 0, 4'b0101);
    exec_instr(5'b01000, 0, 0, 4'b1010);
    exec_instr(5'b01100, 1, 0, 4'b0111);
    exec_instr(5'b01110, 0, 1, 4'b1111);
  endtask

  task automatic test_store;
    exec_instr(5'b01111, 0, 2, 4'b0011);
  endtask

  task automatic test_branch;
    exec_instr(5'b00000, 0, 0, 4'b0001);
    exec_instr(5'b10001, 1, 0, 4'b1110);
    exec_instr(5'b00000, 0, 0, 4'b0000);
    exec_instr(5'b10001, 0, 0, 4'b1111);
    exec_instr(5'b11010, 0, 0, 4'b0000);
    exec_instr(5'b11001, 2, 0, 4'b0000);
    exec_instr(5'b11011, 0, 0, 4'b0000);
    exec_instr(5'b00100, 0, 0, 4'b1000);
    exec_instr(5'b10011, 0, 0, 4'b0000);
    exec_instr(5'b10100, 0, 0, 4'b0000);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++)
      exec_instr(5'($urandom_range(0, 31)), $urandom_range(0, 3),
                 $urandom_range(0, 3), 4'($urandom_range(0, 15)));
  endtask

  task automatic test_mem_reset;
    exec_instr(5'b00000, 0, 0, 4'b1111);
    opcode = 5'b01111;
    for (int k = 0; k < 20 && dmem_req !== 1'b1; k++) begin
      imem_ack = imem_req;
      tick();
    end
    imem_ack = 1'b0;
    total++;
    if (dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL mem_reset_reach: dmem_req %b want 1", dmem_req);
    end
    rst = 1'b1;
    tick();
    total++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || flags !== 4'h0) begin
      bad++;
      $display("FAIL mem_reset: dmem_req %b busy %b flags %b want 0 0 0000",
               dmem_req, busy, flags);
    end
    rst = 1'b0;
    mflags = 4'h0;
    tick();
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL mem_reset_fetch: imem_req %b want 1", imem_req);
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_step;
    int nb;
    step_mode = 1'b1;
    hold_exp  = 1'b1;
    exec_instr(5'b00001, 0, 0, 4'h3);
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy !== 1'b0 || imem_req !== 1'b0) nb++;
      tick();
    end
    total++;
    if (nb != 0) begin
      bad++;
      $display("FAIL hold: %0d active cycles want 0", nb);
    end
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL step_go: imem_req %b want 1", imem_req);
    end
    exec_instr(5'b00010, 1, 0, 4'h4);
    step_mode = 1'b0;
    hold_exp  = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL step_resume: imem_req %b want 1", imem_req);
    end
  endtask
`endif

  task automatic test_timeout;
    int n;
    imem_ack = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && imem_req === 1'b1; k++) begin
      n++;
      tick();
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL tmo_cycles: got %0d want 5", n);
    end
    total++;
    if (err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_err: err %b imem_req %b busy %b want 1 0 0",
               err, imem_req, busy);
    end
    imem_ack = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0;
    total++;
    if (err !== 1'b1 || ir_ld !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL tmo_sticky: err %b ir_ld %b imem_req %b want 1 0 0",
               err, ir_ld, imem_req);
    end
    rst = 1'b1;
    tick();
    total++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: err %b busy %b want 0 0", err, busy);
    end
    rst = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL tmo_restart: imem_req %b want 1", imem_req);
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 5'h0;
    {alu_c, alu_v, alu_s, alu_z} = 4'h0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0;
    step_go   = 1'b0;
`endif
    test_reset();
    test_alu();
    test_store();
    test_branch();
    test_back_to_back();
    test_mem_reset();
`ifdef SEQ_SINGLE_STEP_EN
    test_step();
`endif
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
